clk_period_meter: RTL and testbench

//  Inverse of the clk_div divider: measures the half-period of an external square

---
 rtl/clk_period_meter_pkg.sv | 16 +
 rtl/clk_period_meter_sync_edge.sv | 39 +++
 rtl/clk_period_meter.sv | 149 ++++++++++++++
 tb/tb_clk_period_meter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_meter_pkg
//   Shared definitions for the period meter and its clk_div counterpart.
//   tc convention (shared with clk_div): one output toggle every tc+1 clkin
//   cycles, i.e. f_out = 1/((tc+1)*2*20ns) for a 50 MHz clkin.
// -----------------------------------------------------------------------------
package clk_period_meter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meas_state_t;

  localparam int unsigned CLKIN_PERIOD_NS = 20;

endpackage

// File: rtl/clk_period_meter_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Two-flop synchroniser for an asynchronous input, plus a third flop holding
//   the previous synchronised level so that both edges can be detected.
// Ports
//   clkin    in   system clock
//   rst      in   async reset, active-high (clears all three flops)
//   d        in   asynchronous input
//   q        out  synchronised level
//   edge_det out  high for one cycle after either a rising or a falling edge
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clkin,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic edge_det
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign q        = r_s2;
  assign edge_det = r_s2 ^ r_s3;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//   Measures the half-period of an external square wave in clkin cycles and
//   reports it as tc (half-period minus 1), the same constant clk_div consumes.
// Parameters
//   BIT_SZ  counter / tc width
//   TOL     max |tc_new - tc_prev| still counted as a matching measurement
//   LOCK_N  consecutive matches needed for locked (1..3)
// Ports
//   clkin     in   50 MHz system clock
//   rst       in   async reset, active-high
//   sig_in    in   square wave to measure, asynchronous to clkin
//   tc        out  last valid measurement, stable between tc_valid pulses
//   tc_valid  out  one-cycle pulse when tc is updated
//   overflow  out  sticky: half-period exceeded 2^BIT_SZ-1; cleared by tc_valid
//   locked    out  LOCK_N consecutive measurements within TOL
// -----------------------------------------------------------------------------
module clk_period_meter #(
  parameter int unsigned BIT_SZ = 21,
  parameter int unsigned TOL    = 1,
  parameter int unsigned LOCK_N = 2
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              sig_in,
  output logic [BIT_SZ-1:0] tc,
  output logic              tc_valid,
  output logic              overflow,
  output logic              locked
);
  import clk_period_meter_pkg::*;

  localparam logic [BIT_SZ-1:0] CNT_MAX = '1;
  localparam logic [BIT_SZ-1:0] CNT_ONE = BIT_SZ'(1);
  localparam logic [BIT_SZ-1:0] TOL_V   = BIT_SZ'(TOL);
  localparam logic [1:0]        LOCK_V  = 2'(LOCK_N);

  meas_state_t       r_state;
  meas_state_t       w_state_next;
  logic [BIT_SZ-1:0] r_cnt;
  logic [BIT_SZ-1:0] r_tc;
  logic [BIT_SZ-1:0] r_tc_prev;
  logic              r_tc_valid;
  logic              r_overflow;
  logic              r_locked;
  logic              r_have_prev;
  logic [1:0]        r_match_cnt;

  logic              w_edge;
  logic              w_unused_sig_q;
  logic              w_cnt_max;
  logic              w_capture;
  logic              w_ovf_evt;
  logic [BIT_SZ-1:0] w_diff;
  logic              w_match;
  logic [1:0]        w_match_next;

  sync_edge u_sync (
    .clkin    (clkin),
    .rst      (rst),
    .d        (sig_in),
    .q        (w_unused_sig_q),
    .edge_det (w_edge)
  );

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_ovf_evt    = 1'b0;
    w_cnt_max    = (r_cnt == CNT_MAX);
    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        // A saturated count wins over a coincident edge; that edge still
        // arms the next period, so the FSM stays in MEASURE.
        if (w_cnt_max) begin
          w_ovf_evt    = 1'b1;
          w_state_next = w_edge ? ST_MEASURE : ST_IDLE;
        end else if (w_edge) begin
          w_capture = 1'b1;
        end
      end
    endcase
  end

  // Unsigned distance without wrap: subtract the smaller from the larger.
  always_comb begin
    w_diff       = (r_cnt >= r_tc_prev) ? (r_cnt - r_tc_prev) : (r_tc_prev - r_cnt);
    w_match      = (w_diff <= TOL_V);
    w_match_next = r_match_cnt;
    if (!r_have_prev || !w_match) begin
      w_match_next = '0;
    end else if (r_match_cnt != LOCK_V) begin
      w_match_next = r_match_cnt + 2'd1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_tc        <= '0;
      r_tc_prev   <= '0;
      r_tc_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_locked    <= 1'b0;
      r_have_prev <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_tc_valid <= w_capture;

      if (w_edge) begin
        r_cnt <= '0;
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_capture) begin
        r_tc        <= r_cnt;
        r_overflow  <= 1'b0;
        r_tc_prev   <= r_cnt;
        r_have_prev <= 1'b1;
        r_match_cnt <= w_match_next;
        r_locked    <= (w_match_next == LOCK_V);
      end else if (w_ovf_evt) begin
        // First measurement after an overflow only reloads tc_prev.
        r_overflow  <= 1'b1;
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
        r_match_cnt <= '0;
      end
    end
  end

  assign tc       = r_tc;
  assign tc_valid = r_tc_valid;
  assign overflow = r_overflow;
  assign locked   = r_locked;

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//   Self-checking bench for clk_period_meter (BIT_SZ=8, TOL=1, LOCK_N=2).
//   sig_in toggles are described as a list of half-periods; an event-level
//   reference model turns each half-period into the expected tc_valid pulse
//   (cycle, tc, locked) or overflow assertion, which a per-cycle monitor
//   compares against the DUT.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int unsigned BIT_SZ  = 8;
  localparam int unsigned TOL     = 1;
  localparam int unsigned LOCK_N  = 2;
  localparam int unsigned CNT_MAX = (1 << BIT_SZ) - 1;

  logic              clkin  = 1'b0;
  logic              rst    = 1'b1;
  logic              sig_in = 1'b0;
  logic [BIT_SZ-1:0] tc;
  logic              tc_valid;
  logic              overflow;
  logic              locked;

  clk_period_meter #(
    .BIT_SZ (BIT_SZ),
    .TOL    (TOL),
    .LOCK_N (LOCK_N)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .sig_in   (sig_in),
    .tc       (tc),
    .tc_valid (tc_valid),
    .overflow (overflow),
    .locked   (locked)
  );

  always #5 clkin = ~clkin;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct {
    int unsigned cyc;
    int unsigned tc;
    int unsigned lk;
  } exp_t;

  exp_t vq[$];
  exp_t oq[$];

  bit          m_armed;
  bit          m_have_prev;
  bit          m_ovf;
  int unsigned m_tc_prev;
  int unsigned m_mcnt;
  int unsigned m_tc;
  int unsigned m_last_p;

  task automatic model_reset();
    m_armed     = 0;
    m_have_prev = 0;
    m_ovf       = 0;
    m_tc_prev   = 0;
    m_mcnt      = 0;
    m_tc        = 0;
    m_last_p    = 0;
    vq.delete();
    oq.delete();
  endtask

  // p: posedge index that first samples the new sig_in level.
  // next_gap: half-period until the following toggle (known to the driver).
  task automatic model_toggle(input int unsigned p, input int unsigned next_gap);
    int unsigned h;
    int unsigned tcn;
    int unsigned d;
    if (m_armed) begin
      h = p - m_last_p;
      if (h <= CNT_MAX) begin
        tcn = h - 1;
        if (m_have_prev) begin
          d = (tcn > m_tc_prev) ? tcn - m_tc_prev : m_tc_prev - tcn;
          if (d <= TOL) m_mcnt = (m_mcnt < LOCK_N) ? m_mcnt + 1 : m_mcnt;
          else          m_mcnt = 0;
        end else begin
          m_mcnt = 0;
        end
        m_have_prev = 1;
        m_tc_prev   = tcn;
        m_tc        = tcn;
        m_ovf       = 0;
        vq.push_back('{cyc: p + 2, tc: tcn, lk: (m_mcnt == LOCK_N) ? 1 : 0});
      end
    end
    m_armed  = 1;
    m_last_p = p;
    // Half-period longer than CNT_MAX cycles: overflow once the count saturates.
    if (next_gap > CNT_MAX) begin
      if (!m_ovf) oq.push_back('{cyc: p + CNT_MAX + 3, tc: m_tc, lk: 0});
      m_ovf       = 1;
      m_have_prev = 0;
      m_mcnt      = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic pulse(input int unsigned gap);
    @(negedge clkin);
    sig_in = ~sig_in;
    model_toggle(cyc + 1, gap);
    repeat (gap - 1) @(negedge clkin);
  endtask

  task automatic drain_and_check(input string tag);
    repeat (8) @(negedge clkin);
    check({tag, "_valid_q_empty"}, vq.size(), 0);
    check({tag, "_ovf_q_empty"}, oq.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic prev_ovf = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clkin);
      cyc++;
      #1;
      if (!rst) begin
        if (vq.size() != 0 && vq[0].cyc == cyc) begin
          e = vq.pop_front();
          check("tc_valid", tc_valid, 1);
          check("tc", tc, e.tc);
          check("locked", locked, e.lk);
          check("ovf_clear", overflow, 0);
        end else if (tc_valid) begin
          check("tc_valid_spurious", tc_valid, 0);
        end
        if (oq.size() != 0 && oq[0].cyc == cyc) begin
          e = oq.pop_front();
          check("ovf_rise", {prev_ovf, overflow}, 2'b01);
          check("ovf_tc_hold", tc, e.tc);
          check("ovf_unlock", locked, 0);
        end else if (overflow && !prev_ovf) begin
          check("ovf_spurious", overflow, 0);
        end
      end
      prev_ovf = overflow;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned g;
    model_reset();
    repeat (3) @(negedge clkin);
    check("rst_tc", tc, 0);
    check("rst_tc_valid", tc_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_locked", locked, 0);
    rst = 1'b0;

    // steady tc=5, then lock
    repeat (9) pulse(6);
    // step to tc=9, then +/-1 jitter
    repeat (4) pulse(10);
    repeat (10) pulse($urandom_range(11, 10));
    // hold sig_in constant, then resume
    pulse(6);
    pulse(400);
    repeat (4) pulse(6);
    // largest measurable half-period, then edge coinciding with saturation
    pulse(255);
    pulse(255);
    pulse(6);
    pulse(256);
    repeat (3) pulse(6);
    // fastest input: toggle every cycle
    repeat (12) pulse(1);
    drain_and_check("directed");

    // randomised half-periods with occasional overflow
    repeat (60) begin
      if ($urandom_range(0, 12) == 0) g = $urandom_range(250, 300);
      else                            g = $urandom_range(1, 20);
      pulse(g);
    end
    pulse(300);
    drain_and_check("random");

    // asynchronous reset in the middle of a period
    repeat (5) pulse(6);
    @(negedge clkin);
    sig_in = ~sig_in;
    model_toggle(cyc + 1, 40);
    repeat (20) @(negedge clkin);
    check("pre_rst_tc", tc, m_tc);
    check("pre_rst_locked", locked, 1);
    @(posedge clkin);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tc", tc, 0);
    check("async_rst_tc_valid", tc_valid, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_locked", locked, 0);
    sig_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    repeat (6) pulse(7);
    pulse(300);
    drain_and_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
